// File: rtl/music_player_ctrl.sv
// Score-ROM sequencer for the buzzer: steps one ROM entry per beat and decodes score words into octave/note.
// Optional MUSIC_TEMPO_SEL_EN adds a 2-bit tempo_i input that selects the beat length per entry.
module music_player_ctrl #(
    parameter int unsigned ROM_WIDTH   = 12,
    parameter int unsigned ADDR_WIDTH  = 7,
    parameter int unsigned SONG_LEN    = 128,
    parameter int unsigned BEAT_CYCLES = 25_000_000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  play_i,
    input  logic                  pause_i,
    input  logic                  stop_i,
    input  logic                  loop_en_i,
`ifdef MUSIC_TEMPO_SEL_EN
    input  logic [1:0]            tempo_i,
`endif
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [ROM_WIDTH-1:0]  rom_data_i,
    output logic                  note_valid_o,
    output logic [1:0]            octave_o,
    output logic [3:0]            note_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

`ifdef MUSIC_TEMPO_SEL_EN
    localparam int unsigned CNT_W = $clog2(2 * BEAT_CYCLES);
`else
    localparam int unsigned CNT_W = $clog2(BEAT_CYCLES);
`endif
    localparam logic [CNT_W-1:0]      BEAT_LAST = CNT_W'(BEAT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SONG_LEN - 1);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      beat_q, beat_d;
    logic [CNT_W-1:0]      beat_last_q, beat_last_d;
    logic [CNT_W-1:0]      beat_sel_c;
    logic                  beat_start_c;
    logic                  done_d;
    logic [1:0]            octave_d;
    logic [3:0]            note_d;

    // Terminal count for the entry about to start; latched at each beat start.
`ifdef MUSIC_TEMPO_SEL_EN
    always_comb begin
        case (tempo_i)
            2'd1:    beat_sel_c = CNT_W'(BEAT_CYCLES / 2 - 1);
            2'd2:    beat_sel_c = CNT_W'(2 * BEAT_CYCLES - 1);
            default: beat_sel_c = BEAT_LAST;
        endcase
    end
`else
    assign beat_sel_c = BEAT_LAST;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beat_d       = beat_q;
        done_d       = 1'b0;
        beat_start_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (play_i) begin
                    state_d      = S_PLAY;
                    addr_d       = '0;
                    beat_d       = '0;
                    beat_start_c = 1'b1;
                end
            end
            S_PLAY: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                    beat_d  = '0;
                end else if (pause_i) begin
                    state_d = S_PAUSE;
                end else if (beat_q == beat_last_q) begin
                    beat_d = '0;
                    if (addr_q != LAST_ADDR) begin
                        addr_d       = addr_q + ADDR_WIDTH'(1);
                        beat_start_c = 1'b1;
                    end else if (loop_en_i) begin
                        addr_d       = '0;
                        beat_start_c = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        addr_d  = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    beat_d = beat_q + CNT_W'(1);
                end
            end
            S_PAUSE: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                    beat_d  = '0;
                end else if (play_i) begin
                    state_d = S_PLAY;
                end
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
                beat_d  = '0;
            end
        endcase
    end

    assign beat_last_d = beat_start_c ? beat_sel_c : beat_last_q;

    // First nonzero field wins (high > med > low); a value above 7 is a rest.
    always_comb begin
        octave_d = 2'd0;
        note_d   = 4'd0;
        if (state_q == S_PLAY) begin
            if (rom_data_i[11:8] != 4'd0) begin
                if (rom_data_i[11:8] <= 4'd7) begin
                    octave_d = 2'd3;
                    note_d   = rom_data_i[11:8];
                end
            end else if (rom_data_i[7:4] != 4'd0) begin
                if (rom_data_i[7:4] <= 4'd7) begin
                    octave_d = 2'd2;
                    note_d   = rom_data_i[7:4];
                end
            end else if (rom_data_i[3:0] != 4'd0) begin
                if (rom_data_i[3:0] <= 4'd7) begin
                    octave_d = 2'd1;
                    note_d   = rom_data_i[3:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            beat_q       <= '0;
            beat_last_q  <= BEAT_LAST;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            octave_o     <= 2'd0;
            note_o       <= 4'd0;
            note_valid_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beat_q       <= beat_d;
            beat_last_q  <= beat_last_d;
            busy_o       <= (state_d != S_IDLE);
            done_o       <= done_d;
            octave_o     <= octave_d;
            note_o       <= note_d;
            note_valid_o <= (octave_d != 2'd0);
        end
    end

    assign rom_addr_o = addr_q;

endmodule

// File: doc/music_player_ctrl.md
# music_player_ctrl

Sequencer for the buzzer's music-score ROM. It steps the ROM address once per beat and decodes each 12-bit score word into an octave and note for the tone generator. It handles play, pause and stop commands, and either loops or ends at the end of the song. It sits between the user-control logic (buttons or MMIO) and the score ROM / buzzer tone divider.

## Interface
Parameters:
- ROM_WIDTH, 12, score word width, laid out as {high[3:0], med[3:0], low[3:0]}
- ADDR_WIDTH, 7, ROM address width
- SONG_LEN, 128, number of valid score entries; must be ≤ 2^ADDR_WIDTH and ≥ 2
- BEAT_CYCLES, 25_000_000, clock cycles per score entry (250 ms at 100 MHz); must be ≥ 2

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- play  in  1  single-cycle pulse: start from IDLE, or resume from PAUSED
- pause  in  1  single-cycle pulse: freeze playback
- stop  in  1  single-cycle pulse: abort and return to IDLE
- loop_en  in  1  level; sampled at the last beat of the song
- rom_addr  out  ADDR_WIDTH  registered ROM address
- rom_data  in  ROM_WIDTH  combinational ROM output for rom_addr
- note_valid  out  1  a tone must sound
- octave  out  2  0 = rest, 1 = low, 2 = mid, 3 = high
- note  out  4  note number 1..7, or 0 on rest
- busy  out  1  high in PLAYING or PAUSED
- done  out  1  one-cycle pulse when a non-looping song ends

## Operation
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high (`rst`).
- States: IDLE, PLAYING, PAUSED.
- Command priority when pulses coincide: stop > pause > play.
- IDLE:
  - play → PLAYING, with rom_addr = 0 and beat_cnt = 0.
  - pause and stop are ignored.
- PLAYING:
  - beat_cnt counts 0..BEAT_CYCLES-1.
  - At the terminal count with rom_addr < SONG_LEN-1: rom_addr increments and beat_cnt clears.
  - At the terminal count with rom_addr = SONG_LEN-1: if loop_en, rom_addr wraps to 0 and playback continues; otherwise → IDLE, rom_addr = 0, done pulses.
  - pause → PAUSED; stop → IDLE; play is ignored.
- PAUSED:
  - beat_cnt and rom_addr hold; outputs are forced to rest.
  - play → PLAYING, resuming with the held beat_cnt.
  - stop → IDLE.
- Stop or a terminal count in the same cycle as pause: stop wins. A pause coinciding with a terminal count in PLAYING takes effect, and the address does not advance.
- Decode (in PLAYING only; every other state outputs rest):
  - Field priority is high > med > low.
  - The first nonzero field sets octave = 3/2/1 and note = that field.
  - A selected field value > 7, or an all-zero word, is a rest: octave = 0, note = 0, note_valid = 0.
  - note_valid = (octave != 0).
- Width rules: beat_cnt is $clog2(BEAT_CYCLES) bits. The address compare uses SONG_LEN-1 truncated to ADDR_WIDTH.

## Timing
- Reset values: state = IDLE, rom_addr = 0, beat_cnt = 0, note_valid = 0, octave = 0, note = 0, busy = 0, done = 0.
- rom_addr, busy and state are registered and update on the edge that samples the command or terminal count.
- note/octave/note_valid are registered from rom_data. They lag rom_addr by 1 cycle.
- First note after play: appears 1 cycle after rom_addr = 0 is presented, i.e. 2 edges after the play pulse.
- Each entry is presented for exactly BEAT_CYCLES cycles; there is no dead cycle at address increment or loop wrap.
- done:
  - Asserted for 1 cycle on the same edge that enters IDLE at song end.
  - Not asserted on stop.
- Decode outputs go to rest 1 cycle after entering PAUSED or IDLE.
- rst mid-song: all registers return to reset values on that edge; the commands in that cycle are ignored.

## Configuration
- MUSIC_TEMPO_SEL_EN:
  - Defined: adds input port `tempo` (2 bits). The beat length is BEAT_CYCLES for 0 and 3, BEAT_CYCLES/2 for 1, and BEAT_CYCLES*2 for 2.
  - beat_cnt is widened to hold 2×BEAT_CYCLES.
  - tempo is latched at each beat start (play or address advance), so a change affects only the next entry.
  - Not defined: no tempo port; the beat length is fixed at BEAT_CYCLES.

## Test plan
All scenarios use BEAT_CYCLES=4 and SONG_LEN=8, with a ROM model holding words 0x001, 0x002, 0x000, 0x050, 0x300, 0x009, 0x007, 0x001.
- rst, then play pulse, loop_en=0:
  - rom_addr steps 0..7, each held for 4 cycles.
  - Outputs in order: (1,1), (1,2), rest, (2,5), (3,3), rest, (1,7), (1,1).
  - done pulses once, 32 cycles after rom_addr goes to 0; busy falls on the same edge.
- Same run with loop_en=1: rom_addr wraps from 7 to 0 with no gap, and no done pulse.
- pause at cycle 2 of entry 3, wait 10 cycles, then play: outputs are rest and rom_addr = 3 while paused; entry 3 then completes its remaining 2 cycles.
- pause and stop in the same cycle while PLAYING → IDLE, rom_addr = 0, done = 0. A play pulse in the same cycle as stop is ignored.
- rst asserted mid-entry 5 together with play: the next cycle shows every output at its reset value and state IDLE.
- MUSIC_TEMPO_SEL_EN defined, tempo=2: each entry lasts 8 cycles. tempo switched to 1 mid-entry → the current entry keeps its length, and the next entry lasts 2 cycles.
